dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for a processor MEM stage. Loads are answered
// combinationally in the same cycle. Stores go into a small write buffer and
// are drained into the data array by a two-state FSM. Each drained store
// occupies the array write port for WR_LAT non-load cycles, so loads always
// get the read port and hold off the drain.
//
// Parameters
//   DEPTH    : data array size in 32-bit words (power of two)
//   WB_DEPTH : write-buffer entries (power of two, >= 2)
//   WR_LAT   : non-load cycles of write-port occupancy per drained store (>= 1)
//
// Ports
//   clk               : clock, all state changes on the rising edge
//   rst_n             : asynchronous active-low reset (control state only)
//   proc2Dmem_command : 2'b00 NONE, 2'b01 LOAD, 2'b10 STORE, 2'b11 treated as NONE
//   proc2Dmem_addr    : byte address; word index = addr[log2(DEPTH)+1:2]
//   proc2mem_data     : store data
//   mem2proc_data     : load data (youngest buffered match, else array), 0 if not LOAD
//   wb_count          : number of buffered stores
//   wb_full           : wb_count == WB_DEPTH
//   ovf_err           : sticky, set when a store is dropped
//   ovf_cnt           : dropped-store count (saturating at 255)
//
// Build option
//   DMEM_OVF_CNT_EN : when defined, ovf_cnt is a saturating 8-bit drop counter;
//                     when undefined, ovf_cnt is tied to zero.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH    = 1024,
  parameter int WB_DEPTH = 4,
  parameter int WR_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  proc2Dmem_command,
  input  logic [31:0]                 proc2Dmem_addr,
  input  logic [31:0]                 proc2mem_data,
  output logic [31:0]                 mem2proc_data,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_full,
  output logic                        ovf_err,
  output logic [7:0]                  ovf_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WB_AW = $clog2(WB_DEPTH);
  localparam int CW    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  localparam logic [WB_AW:0]  WB_FULL_CNT = (WB_AW + 1)'(WB_DEPTH);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(WR_LAT - 1);

  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage (not reset: array contents survive reset, buffered entries are
  // invalidated by clearing the pointers/count)
  // ---------------------------------------------------------------------------
  logic [31:0]    r_mem     [DEPTH];
  logic [AW-1:0]  r_wb_idx  [WB_DEPTH];
  logic [31:0]    r_wb_data [WB_DEPTH];

  // Control state
  logic [WB_AW-1:0] r_head;
  logic [WB_AW-1:0] r_tail;
  logic [WB_AW:0]   r_count;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_err;

  // Combinational
  logic             w_is_load;
  logic             w_is_store;
  logic [AW-1:0]    w_idx;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [WB_AW:0]   w_count_next;
  state_t           w_state_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_fwd_hit;
  logic [31:0]      w_fwd_data;
  logic [WB_AW-1:0] w_age [WB_DEPTH];
  logic [WB_DEPTH-1:0] w_hit;
  logic [31-AW:0]   w_unused_addr;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_is_load  = (proc2Dmem_command == BUS_LOAD);
  assign w_is_store = (proc2Dmem_command == BUS_STORE);
  assign w_idx      = proc2Dmem_addr[AW+1:2];

  // Byte offset and bits above the array range do not select anything.
  assign w_unused_addr = {proc2Dmem_addr[31:AW+2], proc2Dmem_addr[1:0]};

  assign w_full = (r_count == WB_FULL_CNT);

  // The head leaves the buffer on the last occupancy cycle of a drain, and only
  // in a cycle that is not using the read port for a load.
  assign w_pop = (r_state == S_WRITE) && !w_is_load && (r_cnt == CNT_LAST);

  // A pop frees a slot at the same edge, so a full buffer still accepts.
  assign w_push = w_is_store && (!w_full || w_pop);
  assign w_drop = w_is_store && !w_push;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // Entering WRITE does not consume an occupancy cycle.
        if (r_count != '0) begin
          w_state_next = S_WRITE;
          w_cnt_next   = '0;
        end
      end
      S_WRITE: begin
        if (!w_is_load) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_next   = '0;
            w_state_next = (w_count_next != '0) ? S_WRITE : S_IDLE;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_count <= w_count_next;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_drop) r_ovf_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer entry write and array write-back
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_idx[r_tail]  <= w_idx;
      r_wb_data[r_tail] <= proc2mem_data;
    end
  end

  // When full with a simultaneous push and pop, tail == head: the array takes
  // the old head contents while the slot is overwritten with the new store.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_mem[r_wb_idx[r_head]] <= r_wb_data[r_head];
    end
  end

  // ---------------------------------------------------------------------------
  // Load forwarding: per-slot age relative to head, then pick the youngest hit
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WB_DEPTH; gi++) begin : g_slot
      assign w_age[gi] = WB_AW'(gi) - r_head;
      assign w_hit[gi] = ({1'b0, w_age[gi]} < r_count) && (r_wb_idx[gi] == w_idx);
    end
  endgenerate

  // Walk from oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (w_hit[r_head + WB_AW'(k)]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[r_head + WB_AW'(k)];
      end
    end
  end

  assign mem2proc_data = !w_is_load ? '0 :
                         (w_fwd_hit ? w_fwd_data : r_mem[w_idx]);

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign wb_count = r_count;
  assign wb_full  = w_full;
  assign ovf_err  = r_ovf_err;

`ifdef DMEM_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  assign ovf_cnt = '0;
`endif

endmodule
